// File: rtl/pe_stream_mac.sv
`default_nettype none
// ============================================================================
//  Module   : pe_stream_mac
//  Purpose  : Streaming multiply-accumulate processing element for a systolic
//             array. Weight (W) and activation (I) streams are buffered,
//             forwarded unchanged to the neighbouring PE and also consumed by
//             a MAC datapath. Mode 0 adds W*I to an upstream partial sum;
//             Mode 1 accumulates ACC_LEN products locally and emits the sum.
//  Ports    : clk, rst                      clock, async active-high reset
//             W_DataIn/Valid/Rdy            weight stream in
//             W_DataOut/Valid/Rdy           weight forward to neighbour
//             I_DataIn/Valid/Rdy            activation stream in
//             I_DataOut/Valid/Rdy           activation forward to neighbour
//             P_DataIn/Valid/Rdy            upstream partial sum (Mode 0)
//             P_DataOut/Valid/Rdy           result / downstream partial sum
//             Mode                          0 = pass-through psum, 1 = local acc
//  Revision : 1.0  initial release
// ============================================================================
module pe_stream_mac #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int DEPTH   = 4,
  parameter int ACC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] W_DataIn,
  input  logic              W_DataInValid,
  output logic              W_DataInRdy,
  output logic [DATA_W-1:0] W_DataOut,
  output logic              W_DataOutValid,
  input  logic              W_DataOutRdy,
  input  logic [DATA_W-1:0] I_DataIn,
  input  logic              I_DataInValid,
  output logic              I_DataInRdy,
  output logic [DATA_W-1:0] I_DataOut,
  output logic              I_DataOutValid,
  input  logic              I_DataOutRdy,
  input  logic [ACC_W-1:0]  P_DataIn,
  input  logic              P_DataInValid,
  output logic              P_DataInRdy,
  output logic [ACC_W-1:0]  P_DataOut,
  output logic              P_DataOutValid,
  input  logic              P_DataOutRdy,
  input  logic              Mode
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_PTR_W  = c_ADDR_W + 1;
  localparam int c_CNT_W  = $clog2(ACC_LEN + 1);
  localparam logic [c_PTR_W-1:0] c_DEPTH    = c_PTR_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACC_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [DATA_W-1:0]  r_wMem [DEPTH];
  logic [DATA_W-1:0]  r_iMem [DEPTH];
  logic [c_PTR_W-1:0] r_wTail, r_wFwd, r_wMac;
  logic [c_PTR_W-1:0] r_iTail, r_iFwd, r_iMac;
  logic               r_run;
  logic [c_CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_pOut;
  logic               r_pValid;

  logic               w_wFull, w_iFull;
  logic               w_wInXfer, w_iInXfer, w_wFwdXfer, w_iFwdXfer;
  logic               w_fire, w_last;
  logic [DATA_W-1:0]  w_wOp, w_iOp;
  logic [ACC_W-1:0]   w_wExt, w_iExt, w_prod, w_accBase, w_accNext;

  // An entry stays occupied until both the forward and MAC readers are past it,
  // so fullness is measured against whichever reader lags.
  assign w_wFull = ((r_wTail - r_wFwd) == c_DEPTH) || ((r_wTail - r_wMac) == c_DEPTH);
  assign w_iFull = ((r_iTail - r_iFwd) == c_DEPTH) || ((r_iTail - r_iMac) == c_DEPTH);

  // r_run holds Rdy low while reset is asserted and until the first clock edge.
  assign W_DataInRdy = r_run && !w_wFull;
  assign I_DataInRdy = r_run && !w_iFull;

  assign W_DataOutValid = (r_wTail != r_wFwd);
  assign I_DataOutValid = (r_iTail != r_iFwd);
  assign W_DataOut      = r_wMem[r_wFwd[c_ADDR_W-1:0]];
  assign I_DataOut      = r_iMem[r_iFwd[c_ADDR_W-1:0]];

  assign w_wInXfer  = W_DataInValid && W_DataInRdy;
  assign w_iInXfer  = I_DataInValid && I_DataInRdy;
  assign w_wFwdXfer = W_DataOutValid && W_DataOutRdy;
  assign w_iFwdXfer = I_DataOutValid && I_DataOutRdy;

  assign w_fire = (r_wMac != r_wTail) && (r_iMac != r_iTail) &&
                  (!r_pValid || P_DataOutRdy) && (Mode || P_DataInValid);

  assign P_DataInRdy    = !Mode && w_fire;
  assign P_DataOut      = r_pOut;
  assign P_DataOutValid = r_pValid;

  // Operands are sign-extended to the accumulator width before multiplying;
  // the low ACC_W bits then equal the sign-extended DATA_W x DATA_W product.
  assign w_wOp     = r_wMem[r_wMac[c_ADDR_W-1:0]];
  assign w_iOp     = r_iMem[r_iMac[c_ADDR_W-1:0]];
  assign w_wExt    = {{(ACC_W-DATA_W){w_wOp[DATA_W-1]}}, w_wOp};
  assign w_iExt    = {{(ACC_W-DATA_W){w_iOp[DATA_W-1]}}, w_iOp};
  assign w_prod    = w_wExt * w_iExt;
  assign w_accBase = (r_cnt == '0) ? '0 : r_acc;
  assign w_accNext = w_accBase + w_prod;
  assign w_last    = (r_cnt == c_CNT_LAST);

  // Buffer storage carries no reset; pointers make stale entries unreadable.
  always_ff @(posedge clk) begin
    if (w_wInXfer) r_wMem[r_wTail[c_ADDR_W-1:0]] <= W_DataIn;
    if (w_iInXfer) r_iMem[r_iTail[c_ADDR_W-1:0]] <= I_DataIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_wTail  <= '0;
      r_wFwd   <= '0;
      r_wMac   <= '0;
      r_iTail  <= '0;
      r_iFwd   <= '0;
      r_iMac   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_pOut   <= '0;
      r_pValid <= 1'b0;
    end else begin
      r_run <= 1'b1;

      if (w_wInXfer)  r_wTail <= r_wTail + c_PTR_ONE;
      if (w_iInXfer)  r_iTail <= r_iTail + c_PTR_ONE;
      if (w_wFwdXfer) r_wFwd  <= r_wFwd + c_PTR_ONE;
      if (w_iFwdXfer) r_iFwd  <= r_iFwd + c_PTR_ONE;
      if (w_fire) begin
        r_wMac <= r_wMac + c_PTR_ONE;
        r_iMac <= r_iMac + c_PTR_ONE;
      end

      // Any Mode-0 cycle throws away a partial local accumulation.
      if (!Mode) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_fire) begin
        r_acc <= w_accNext;
        r_cnt <= w_last ? '0 : (r_cnt + c_CNT_ONE);
      end

      // A new result may reload the slot in the same cycle it drains.
      if (w_fire && (!Mode || w_last)) begin
        r_pValid <= 1'b1;
        r_pOut   <= Mode ? w_accNext : (P_DataIn + w_prod);
      end else if (P_DataOutRdy) begin
        r_pValid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
